// File: rtl/glitchcraft_pkg.sv
// ---------------------------------------------------------------------------
// glitchcraft_pkg
//   Shared types and constants for the glitchcraft fault-injection timer.
//   - state_t          : sequencer states (LOAD, ARMED, DELAY, GLITCH, DONE)
//   - DEFAULT_DELAY_W  : default width of the delay field / counter
//   - DEFAULT_WIDTH_W  : default width of the pulse-width field / counter
//   - FRAME_LEN        : serial config frame length for the default widths
//   - frame_len()      : frame length for arbitrary field widths
// ---------------------------------------------------------------------------
package glitchcraft_pkg;

  localparam int DEFAULT_DELAY_W = 64;
  localparam int DEFAULT_WIDTH_W = 64;

  // delay field, width field, then one polarity bit
  localparam int FRAME_LEN = DEFAULT_DELAY_W + DEFAULT_WIDTH_W + 1;

  typedef enum logic [2:0] {
    ST_LOAD   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_DELAY  = 3'd2,
    ST_GLITCH = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  function automatic int frame_len(input int delay_w, input int width_w);
    return delay_w + width_w + 1;
  endfunction

endpackage

// File: rtl/glitchcraft_cfg_shift.sv
// ---------------------------------------------------------------------------
// glitchcraft_cfg_shift
//   Serial configuration loader. Takes one bit of t_data per cycle while
//   enable is high, MSB first: delay[DELAY_W-1:0], width[WIDTH_W-1:0],
//   polarity. After the polarity bit is captured load_done rises and the
//   loader freezes until enable drops or rst is asserted.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   enable     in   synchronous clear when low
//   t_data     in   serial config bit
//   delay      out  loaded delay field
//   width      out  loaded pulse-width field
//   polarity   out  loaded polarity bit (0 = active-high pulse)
//   load_done  out  whole frame captured
// ---------------------------------------------------------------------------
module glitchcraft_cfg_shift
  import glitchcraft_pkg::*;
#(
  parameter int DELAY_W = DEFAULT_DELAY_W,
  parameter int WIDTH_W = DEFAULT_WIDTH_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               t_data,
  output logic [DELAY_W-1:0] delay,
  output logic [WIDTH_W-1:0] width,
  output logic               polarity,
  output logic               load_done
);

  localparam int FIELD_LEN = DELAY_W + WIDTH_W;
  localparam int FLEN      = frame_len(DELAY_W, WIDTH_W);
  localparam int CNT_W     = $clog2(FLEN + 1);

  // The polarity bit is kept out of the shift register so that the glitch
  // idle level never follows the raw bit stream while a frame is arriving.
  logic [FIELD_LEN-1:0] sr;
  logic [CNT_W-1:0]     bit_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr        <= '0;
      bit_cnt   <= '0;
      polarity  <= 1'b0;
      load_done <= 1'b0;
    end else if (!enable) begin
      sr        <= '0;
      bit_cnt   <= '0;
      polarity  <= 1'b0;
      load_done <= 1'b0;
    end else if (!load_done) begin
      bit_cnt <= bit_cnt + CNT_W'(1);
      if (bit_cnt == CNT_W'(FIELD_LEN)) begin
        // last bit of the frame is the polarity bit
        polarity  <= t_data;
        load_done <= 1'b1;
      end else begin
        sr <= {sr[FIELD_LEN-2:0], t_data};
      end
    end
  end

  // delay arrived first, so it sits in the upper bits once the frame is in
  assign delay = sr[FIELD_LEN-1 -: DELAY_W];
  assign width = sr[WIDTH_W-1:0];

endmodule

// File: rtl/glitchcraft_core.sv
// ---------------------------------------------------------------------------
// glitchcraft_core
//   Fault-injection glitch timer. A serial config frame sets delay, pulse
//   width and polarity. Once loaded the block is armed; on go it releases
//   targetreset, waits delay+1 cycles, then drives one glitch pulse of
//   `width` cycles and parks in DONE until enable drops or rst.
//
// Ports
//   SYSCLK_P     in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   enable       in   synchronous soft reset when low
//   t_data       in   serial config bit
//   go           in   level trigger, honoured only while armed
//   armed        out  config loaded, waiting for go
//   done         out  glitch sequence complete
//   glitch       out  glitch drive (active level set by polarity)
//   targetreset  out  holds the target in reset until go
//   led2         out  copy of armed
//   led3         out  copy of done
//   dbg_state    out  current sequencer state
//
// Handshake: there is no valid/ready pair here. go is a level sampled on
// every rising edge while ARMED; the first edge that sees it high starts
// the sequence and later values of go are ignored until a full reload.
// ---------------------------------------------------------------------------
module glitchcraft_core
  import glitchcraft_pkg::*;
#(
  parameter int DELAY_W = DEFAULT_DELAY_W,
  parameter int WIDTH_W = DEFAULT_WIDTH_W
) (
  input  logic   SYSCLK_P,
  input  logic   rst,
  input  logic   enable,
  input  logic   t_data,
  input  logic   go,
  output logic   armed,
  output logic   done,
  output logic   glitch,
  output logic   targetreset,
  output logic   led2,
  output logic   led3,
  output state_t dbg_state
);

  // one counter serves both the delay and the pulse phases
  localparam int CW = (DELAY_W > WIDTH_W) ? DELAY_W : WIDTH_W;

  logic [DELAY_W-1:0] cfg_delay;
  logic [WIDTH_W-1:0] cfg_width;
  logic               cfg_polarity;
  logic               load_done;

  state_t             state;
  logic [CW-1:0]      cnt;

  glitchcraft_cfg_shift #(
    .DELAY_W (DELAY_W),
    .WIDTH_W (WIDTH_W)
  ) u_cfg_shift (
    .clk       (SYSCLK_P),
    .rst       (rst),
    .enable    (enable),
    .t_data    (t_data),
    .delay     (cfg_delay),
    .width     (cfg_width),
    .polarity  (cfg_polarity),
    .load_done (load_done)
  );

  // Every output is a flop written here. glitch holds active ^ polarity;
  // it stays 0 during LOAD and takes the idle level when ARMED is entered,
  // by which time the polarity register is already valid.
  always_ff @(posedge SYSCLK_P or posedge rst) begin
    if (rst) begin
      state       <= ST_LOAD;
      cnt         <= '0;
      armed       <= 1'b0;
      done        <= 1'b0;
      targetreset <= 1'b1;
      glitch      <= 1'b0;
    end else if (!enable) begin
      state       <= ST_LOAD;
      cnt         <= '0;
      armed       <= 1'b0;
      done        <= 1'b0;
      targetreset <= 1'b1;
      glitch      <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (load_done) begin
            state  <= ST_ARMED;
            armed  <= 1'b1;
            glitch <= cfg_polarity;
          end
        end

        ST_ARMED: begin
          if (go) begin
            state       <= ST_DELAY;
            armed       <= 1'b0;
            targetreset <= 1'b0;
            cnt         <= CW'(cfg_delay);
          end
        end

        // Counting down to zero and then spending the zero cycle here is
        // what places the first pulse cycle delay+1 edges after go.
        ST_DELAY: begin
          if (cnt == '0) begin
            state  <= ST_GLITCH;
            cnt    <= CW'(cfg_width);
            glitch <= cfg_polarity ^ (cfg_width != '0);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        // cnt holds the pulse cycles still to run including the current
        // one; width==0 passes through a single idle cycle.
        ST_GLITCH: begin
          if (cnt <= CW'(1)) begin
            state  <= ST_DONE;
            done   <= 1'b1;
            glitch <= cfg_polarity;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        ST_DONE: begin
          // parked until enable drops or rst
        end

        default: begin
          state <= ST_LOAD;
        end
      endcase
    end
  end

  assign led2      = armed;
  assign led3      = done;
  assign dbg_state = state;

endmodule

// File: tb/tb_glitchcraft_core.sv
// ---------------------------------------------------------------------------
// tb_glitchcraft_core
//   Drives config frames and go triggers into glitchcraft_core and compares
//   {armed, done, targetreset, glitch} against a timeline computed from the
//   delay/width/polarity rules of the timer.
// ---------------------------------------------------------------------------
module tb_glitchcraft_core;
  import glitchcraft_pkg::*;

  localparam int DW   = DEFAULT_DELAY_W;
  localparam int WW   = DEFAULT_WIDTH_W;
  localparam int FLEN = DW + WW + 1;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst;
  logic   enable;
  logic   t_data;
  logic   go;
  logic   armed;
  logic   done;
  logic   glitch;
  logic   targetreset;
  logic   led2;
  logic   led3;
  state_t dbg_state;

  always #5 clk = ~clk;

  glitchcraft_core #(
    .DELAY_W (DW),
    .WIDTH_W (WW)
  ) dut (
    .SYSCLK_P    (clk),
    .rst         (rst),
    .enable      (enable),
    .t_data      (t_data),
    .go          (go),
    .armed       (armed),
    .done        (done),
    .glitch      (glitch),
    .targetreset (targetreset),
    .led2        (led2),
    .led3        (led3),
    .dbg_state   (dbg_state)
  );

  // observed vector: {armed, done, targetreset, glitch}
  logic [3:0] obs_vec;
  assign obs_vec = {armed, done, targetreset, glitch};

  // ---------------- scoreboard ----------------
  int         n_vec = 0;
  int         n_err = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // inputs change at negedge, outputs are sampled at the following negedge
  task automatic step();
    @(negedge clk);
  endtask

  task automatic shift_frame(input int d, input int w, input logic p);
    logic [FLEN-1:0] frame;
    frame  = {DW'(d), WW'(w), p};
    enable = 1'b1;
    for (int i = FLEN - 1; i >= 0; i--) begin
      t_data = frame[i];
      go     = 1'($urandom_range(0, 1));   // go while loading must be ignored
      step();
      check("load_idle", obs_vec, 4'b0010);
    end
    t_data = 1'($urandom_range(0, 1));
    go     = 1'b0;
    step();
    check("armed", obs_vec, {1'b1, 1'b0, 1'b1, p});
    check("led2", led2, 1);
    step();
    check("armed_hold", obs_vec, {1'b1, 1'b0, 1'b1, p});
  endtask

  // Reference timeline, k = edges after the one that samples go:
  //   targetreset low from k=0, pulse active for k in [d+1, d+w],
  //   done from k = d+1+max(w,1). go stays high to check no retrigger.
  task automatic run_go(input int d, input int w, input logic p);
    int         wl;
    int         total;
    logic       act;
    logic [3:0] e;
    int         k;
    wl    = (w == 0) ? 1 : w;
    total = d + 1 + wl + 3;
    exp_q.delete();
    for (int kk = 0; kk < total; kk++) begin
      act = (kk >= d + 1) && (kk <= d + w);
      exp_q.push_back({1'b0, 1'(kk >= d + 1 + wl), 1'b0, p ^ act});
    end
    go = 1'b1;
    k  = 0;
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      check($sformatf("seq_d%0d_w%0d_p%0d_k%0d", d, w, p, k), obs_vec, e);
      k++;
    end
    check("led3", led3, 1);
  endtask

  task automatic drop_enable();
    enable = 1'b0;
    step();
    check("cleared_1", obs_vec, 4'b0010);
    step();
    check("cleared_2", obs_vec, 4'b0010);
    check("leds_cleared", {led2, led3}, 2'b00);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   d;
    int   w;
    logic p;

    rst    = 1'b1;
    enable = 1'b0;
    t_data = 1'b0;
    go     = 1'b0;
    repeat (3) step();
    check("reset_state", obs_vec, 4'b0010);
    rst = 1'b0;
    step();
    check("idle_disabled", obs_vec, 4'b0010);

    // nominal frame, active-high pulse
    shift_frame(3, 3, 1'b0);
    run_go(3, 3, 1'b0);
    // enable pulse in DONE with go still high
    drop_enable();

    // same frame, active-low pulse
    shift_frame(3, 3, 1'b1);
    run_go(3, 3, 1'b1);
    drop_enable();

    // zero delay, zero width
    shift_frame(0, 0, 1'b0);
    run_go(0, 0, 1'b0);
    drop_enable();

    // randomized frames
    repeat (8) begin
      d = $urandom_range(0, 6);
      w = $urandom_range(0, 6);
      p = 1'($urandom_range(0, 1));
      shift_frame(d, w, p);
      run_go(d, w, p);
      drop_enable();
    end

    // asynchronous reset in the middle of the pulse
    shift_frame(2, 5, 1'b0);
    go = 1'b1;
    repeat (4) step();
    check("pre_rst_glitch", obs_vec, 4'b0001);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", obs_vec, 4'b0010);
    step();
    go  = 1'b0;
    rst = 1'b0;
    step();
    check("post_rst", obs_vec, 4'b0010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
